// File: rtl/nsquare_requester_if.sv
// Request/result handshake between the sum-of-squares requester (master) and the engine (slave).
interface nsquare_requester_if #(
  parameter int NW = 3,
  parameter int SW = 8
) ();
  logic [NW-1:0] N;
  logic          N_valid;
  logic          ack;
  logic [SW-1:0] sum_out;
  logic          sum_valid;

  modport master (output N, N_valid, ack, input sum_out, sum_valid);
  modport slave  (input N, N_valid, ack, output sum_out, sum_valid);
endinterface

// File: rtl/nsquare_requester.sv
// Sweeps N over a wrapping range into the sum-of-squares engine and checks each result.
// Optional feature macro: NSQ_REQ_SELFCHECK_EN (expected-value compare and pass/fail counters).
module nsquare_requester #(
  parameter int NW         = 3,
  parameter int SW         = 8,
  parameter int ACK_CYCLES = 1,
  parameter int TIMEOUT    = 63
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 start,
  input  logic [NW-1:0]        n_first,
  input  logic [NW-1:0]        n_last,
  nsquare_requester_if.master  eng,
  output logic                 busy,
  output logic                 done,
  output logic [SW-1:0]        last_sum,
  output logic [7:0]           pass_count,
  output logic [7:0]           fail_count,
  output logic                 timeout_err
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK, S_NEXT, S_DONE} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [NW-1:0] r_n;
  logic [NW-1:0] r_n_last;
  logic [7:0]    r_tmo;
  logic [3:0]    r_ack_cnt;
  logic [SW-1:0] r_last_sum;
  logic          r_timeout_err;
  logic          w_n_valid;
  logic          w_ack;
  logic          w_done;
  logic          w_busy;
  logic          w_start_take;
  logic          w_result_take;
  logic          w_timeout_hit;

  assign w_start_take  = (r_state == S_IDLE) && start;
  assign w_result_take = (r_state == S_WAIT) && eng.sum_valid;
  // sum_valid outranks a simultaneous timeout expiry
  assign w_timeout_hit = (r_state == S_WAIT) && !eng.sum_valid && (r_tmo == 8'(TIMEOUT - 1));

  always_ff @(posedge Clk) begin
    if (Rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_n_valid    = 1'b0;
    w_ack        = 1'b0;
    w_done       = 1'b0;
    w_busy       = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (start) w_state_next = S_ISSUE;
      end
      S_ISSUE: begin
        w_n_valid    = 1'b1;
        w_state_next = S_WAIT;
      end
      S_WAIT: begin
        if (eng.sum_valid)  w_state_next = S_ACK;
        else if (w_timeout_hit) w_state_next = S_NEXT;
      end
      S_ACK: begin
        w_ack = 1'b1;
        if ((r_ack_cnt >= 4'(ACK_CYCLES - 1)) && !eng.sum_valid) w_state_next = S_NEXT;
      end
      S_NEXT: begin
        w_state_next = (r_n == r_n_last) ? S_DONE : S_ISSUE;
      end
      S_DONE: begin
        w_done       = 1'b1;
        w_busy       = 1'b0;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_n           <= '0;
      r_n_last      <= '0;
      r_tmo         <= '0;
      r_ack_cnt     <= '0;
      r_last_sum    <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_start_take) begin
        r_n           <= n_first;
        r_n_last      <= n_last;
        r_timeout_err <= 1'b0;
      end
      if (r_state == S_ISSUE) r_tmo <= '0;
      if (w_result_take) begin
        r_last_sum <= eng.sum_out;
        r_ack_cnt  <= '0;
      end else if (w_timeout_hit) begin
        r_timeout_err <= 1'b1;
      end else if (r_state == S_WAIT) begin
        r_tmo <= r_tmo + 8'd1;
      end
      if ((r_state == S_ACK) && (r_ack_cnt != 4'hF)) r_ack_cnt <= r_ack_cnt + 4'd1;
      if ((r_state == S_NEXT) && (r_n != r_n_last)) r_n <= r_n + 1'b1;
    end
  end

`ifdef NSQ_REQ_SELFCHECK_EN
  logic [11:0] w_exp_tab [2**NW];
  logic        w_match;
  logic [7:0]  r_pass;
  logic [7:0]  r_fail;

  // Closed-form N(N+1)(2N+1)/6 folded into a constant table indexed by N
  for (genvar gi = 0; gi < 2**NW; gi++) begin : g_exp
    assign w_exp_tab[gi] = 12'((gi * (gi + 1) * (2 * gi + 1)) / 6);
  end

  assign w_match = (w_exp_tab[r_n] == 12'(eng.sum_out));

  always_ff @(posedge Clk) begin
    if (Rst || w_start_take) begin
      r_pass <= '0;
      r_fail <= '0;
    end else if (w_result_take && w_match) begin
      if (r_pass != 8'hFF) r_pass <= r_pass + 8'd1;
    end else if (w_result_take || w_timeout_hit) begin
      if (r_fail != 8'hFF) r_fail <= r_fail + 8'd1;
    end
  end

  assign pass_count = r_pass;
  assign fail_count = r_fail;
`else
  assign pass_count = 8'd0;
  assign fail_count = 8'd0;
`endif

  assign eng.N       = r_n;
  assign eng.N_valid = w_n_valid;
  assign eng.ack     = w_ack;
  assign busy        = w_busy;
  assign done        = w_done;
  assign last_sum    = r_last_sum;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_nsquare_requester.sv
// Scoreboard bench: stimulus queues expected requests/acks/done results, a negedge monitor checks them.
module tb_nsquare_requester;

`ifdef NSQ_REQ_SELFCHECK_EN
  localparam bit SC = 1'b1;
`else
  localparam bit SC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [2:0] n_first = '0;
  logic [2:0] n_last = '0;
  logic       busy, done, timeout_err;
  logic [7:0] last_sum, pass_count, fail_count;

  nsquare_requester_if #(.NW(3), .SW(8)) bus ();

  nsquare_requester #(.NW(3), .SW(8), .ACK_CYCLES(1), .TIMEOUT(15)) dut (
    .Clk(clk), .Rst(rst), .start(start), .n_first(n_first), .n_last(n_last),
    .eng(bus), .busy(busy), .done(done), .last_sum(last_sum),
    .pass_count(pass_count), .fail_count(fail_count), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int last;
    int pass;
    int fail;
    int terr;
    int delta;
  } done_t;

  int    exp_req[$];
  int    exp_ack[$];
  done_t exp_done[$];
  int    total = 0;
  int    bad = 0;
  int    done_seen = 0;
  int    cyc = 0;
  int    last_nv_cyc = 0;
  int    ack_len = 0;
  int    eng_mode = 0;   // 0 correct, 1 wrong value for N=3, 2 never responds
  int    hold_extra = 0; // extra cycles sum_valid stays high after ack is seen
  int    sq_tab[8] = '{0, 1, 5, 14, 30, 55, 91, 140};

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Engine model, driven on the falling edge
  initial begin
    int e_st = 0, e_lat = 0, e_rem = 0, e_n = 0;
    bus.sum_valid = 1'b0;
    bus.sum_out   = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        e_st = 0;
        bus.sum_valid = 1'b0;
        bus.sum_out   = '0;
      end else begin
        case (e_st)
          0: if (bus.N_valid && eng_mode != 2) begin
               e_n = int'(bus.N); e_lat = 2; e_st = 1;
             end
          1: begin
               e_lat--;
               if (e_lat == 0) begin
                 bus.sum_valid = 1'b1;
                 bus.sum_out   = (eng_mode == 1 && e_n == 3) ? 8'd15 : 8'(sq_tab[e_n]);
                 e_rem = hold_extra;
                 e_st  = 2;
               end
             end
          default: if (bus.ack) begin
               if (e_rem == 0) begin
                 bus.sum_valid = 1'b0; e_st = 0;
               end else e_rem--;
             end
        endcase
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a request, an ack, or done
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.N_valid) begin
        last_nv_cyc = cyc;
        if (exp_req.size() == 0) chk("unexpected_req", int'(bus.N), -1);
        else chk("req_N", int'(bus.N), exp_req.pop_front());
      end
      if (bus.ack) ack_len++;
      else if (ack_len > 0) begin
        if (exp_ack.size() == 0) chk("unexpected_ack_len", ack_len, -1);
        else chk("ack_len", ack_len, exp_ack.pop_front());
        ack_len = 0;
      end
      if (done) begin
        done_t d;
        done_seen++;
        chk("done_busy", int'(busy), 0);
        chk("done_nvalid_ack", int'(bus.N_valid | bus.ack), 0);
        if (exp_done.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          d = exp_done.pop_front();
          chk("last_sum", int'(last_sum), d.last);
          chk("pass_count", int'(pass_count), d.pass);
          chk("fail_count", int'(fail_count), d.fail);
          chk("timeout_err", int'(timeout_err), d.terr);
          if (d.delta >= 0) chk("done_delay", cyc - last_nv_cyc, d.delta);
        end
      end
    end
  end

  task automatic run_sweep(input int f, input int l, input int mode, input int hold);
    int d0;
    bit seen;
    eng_mode = mode;
    hold_extra = hold;
    d0 = done_seen;
    @(negedge clk);
    start = 1'b1; n_first = 3'(f); n_last = 3'(l);
    @(negedge clk);
    start = 1'b0;
    chk("start_nvalid", int'(bus.N_valid), 1);
    chk("start_busy", int'(busy), 1);
    seen = 1'b0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      @(negedge clk);
      if (done_seen != d0) seen = 1'b1;
    end
    if (!seen) begin
      total++; bad++;
      $display("FAIL sweep_done_wait: got no done expected done for %0d..%0d", f, l);
    end
    $display("sweep %0d..%0d mode=%0d done: last_sum=%0d pass=%0d fail=%0d terr=%0d",
             f, l, mode, last_sum, pass_count, fail_count, timeout_err);
  endtask

  initial begin
    bit hit;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_N", int'(bus.N), 0);
    chk("rst_nvalid", int'(bus.N_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_last_sum", int'(last_sum), 0);

    // Full sweep 0..7
    for (int i = 0; i < 8; i++) begin exp_req.push_back(i); exp_ack.push_back(1); end
    exp_done.push_back('{140, SC ? 8 : 0, 0, 0, -1});
    run_sweep(0, 7, 0, 0);

    // Single point
    exp_req.push_back(4); exp_ack.push_back(1);
    exp_done.push_back('{30, SC ? 1 : 0, 0, 0, -1});
    run_sweep(4, 4, 0, 0);

    // Mismatch: engine returns 15 for N=3
    exp_req.push_back(3); exp_ack.push_back(1);
    exp_done.push_back('{15, 0, SC ? 1 : 0, 0, -1});
    run_sweep(3, 3, 1, 0);

    // Timeout: no response, last_sum keeps the previous capture
    exp_req.push_back(5);
    exp_done.push_back('{15, 0, SC ? 1 : 0, 1, 17});
    run_sweep(5, 5, 2, 0);

    // Wrapping range with long sum_valid hold
    exp_req.push_back(6); exp_req.push_back(7); exp_req.push_back(0); exp_req.push_back(1);
    for (int i = 0; i < 4; i++) exp_ack.push_back(4);
    exp_done.push_back('{1, SC ? 4 : 0, 0, 0, -1});
    run_sweep(6, 1, 0, 3);

    // Extra starts while busy are ignored; reset while waiting on N=4
    eng_mode = 0; hold_extra = 0;
    exp_req.push_back(2); exp_req.push_back(3); exp_req.push_back(4);
    exp_ack.push_back(1); exp_ack.push_back(1);
    @(negedge clk);
    start = 1'b1; n_first = 3'd2; n_last = 3'd5;
    @(negedge clk);
    n_first = 3'd0; n_last = 3'd0;
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      if (i == 3) start = 1'b0;
      if (bus.N_valid && bus.N == 3'd4) hit = 1'b1;
    end
    start = 1'b0;
    chk("reached_N4", int'(hit), 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_N", int'(bus.N), 0);
    chk("midrst_nvalid", int'(bus.N_valid), 0);
    chk("midrst_ack", int'(bus.ack), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_last_sum", int'(last_sum), 0);
    chk("midrst_pass", int'(pass_count), 0);
    chk("midrst_fail", int'(fail_count), 0);
    chk("midrst_terr", int'(timeout_err), 0);
    $display("reset mid-WAIT: N=%0d busy=%0d last_sum=%0d", bus.N, busy, last_sum);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    chk("pending_req", exp_req.size(), 0);
    chk("pending_ack", exp_ack.size(), 0);
    chk("pending_done", exp_done.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nsquare_requester.md
# nsquare_requester

Host-side requester for the sum-of-squares engine. It sweeps a programmed range of N values into the engine over the N/N_valid request interface and collects each sum_out/sum_valid result. It returns ack to release each result and checks every result against the closed-form sum of squares. It sits in front of the engine as its initiator, for on-chip self-test and for driving sweeps from a control register block.

## Interface
Parameters:
- NW, 3, width of N.
- SW, 8, width of sum_out and last_sum.
- ACK_CYCLES, 1, minimum number of cycles ack is held high, 1..15.
- TIMEOUT, 63, maximum WAIT cycles before abandoning a request, 1..255.

Ports:
- Clk  input  1  the single clock; all state updates on its rising edge.
- Rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to begin a sweep; sampled only in IDLE.
- n_first  input  NW  first N of the sweep; latched on start.
- n_last  input  NW  last N of the sweep; latched on start.
- N  output  NW  N value presented to the engine.
- N_valid  output  1  request strobe to the engine.
- ack  output  1  result acknowledge to the engine.
- sum_out  input  SW  engine result.
- sum_valid  input  1  engine result valid; level, held until acked.
- busy  output  1  high from the cycle after start until done.
- done  output  1  one-cycle pulse when the sweep ends.
- last_sum  output  SW  most recently captured sum_out.
- pass_count  output  8  results matching the expected value.
- fail_count  output  8  mismatches plus timeouts.
- timeout_err  output  1  sticky; set on any timeout, cleared by the next accepted start or by Rst.

## Operation
States and transitions:
- IDLE: accepted start latches the range, clears the counters and timeout_err, loads N=n_first, and goes to ISSUE. start while busy is ignored.
- ISSUE: N_valid=1 for exactly one cycle, then go to WAIT.
- WAIT: the timeout counter increments each cycle.
  - sum_valid=1: capture sum_out into last_sum, compare, go to ACK.
  - Counter reaches TIMEOUT: set timeout_err, increment fail_count, go to NEXT without ack.
- ACK: ack=1 for at least ACK_CYCLES cycles, and kept high until sum_valid is sampled low. Then go to NEXT.
- NEXT: if N==n_last, go to DONE. Otherwise N <= N+1 modulo 2^NW and go to ISSUE.
- DONE: done=1 for one cycle, then go to IDLE.

Arithmetic and range rules:
- Expected value is N(N+1)(2N+1)/6, computed in 12 bits and compared against the zero-extended sum_out. For NW=3 the values are 0,1,5,14,30,55,91,140.
- Counters saturate at 255.
- Range wraps. n_first > n_last sweeps upward through 2^NW-1 and 0 to n_last. n_first==n_last performs exactly one transaction.

## Timing
- Reset values: N=0, N_valid=0, ack=0, busy=0, done=0, last_sum=0, pass_count=0, fail_count=0, timeout_err=0, state IDLE.
- Rst=1 in any state forces the reset values at that edge. An in-flight engine request is abandoned.
- start sampled at edge t:
  - N and N_valid=1 appear at t+1.
  - busy=1 from t+1.
- sum_valid sampled high at edge w:
  - last_sum and the counters update at w.
  - ack=1 from w+1.
- ack falls one cycle after the edge that satisfies both the ACK_CYCLES minimum and the sum_valid=0 condition.
- Next N_valid follows after one NEXT cycle, so requests are never back-to-back.
- If sum_valid and the timeout expiry occur in the same cycle, sum_valid wins: the result counts and no timeout is recorded.
- done and busy=0 occur in the same cycle. done is never high while N_valid or ack is high.

## Configuration
- NSQ_REQ_SELFCHECK_EN defined:
  - Expected-value computation and the comparison are compiled in.
  - pass_count and fail_count behave as specified.
- NSQ_REQ_SELFCHECK_EN undefined:
  - No comparator or expected-value logic.
  - pass_count and fail_count are tied to 0.
  - last_sum, timeout_err, the handshakes and the sweep sequencing are unchanged.

## Test plan
- Full sweep: n_first=0, n_last=7, against a correct engine model -> 8 request/ack handshakes with N=0..7, pass_count=8, fail_count=0, last_sum=140, single done pulse.
- Single point: n_first=n_last=4 -> exactly one N_valid pulse with N=4, last_sum=30, pass_count=1.
- Mismatch: model returns 15 for N=3 during a 3..3 sweep -> fail_count=1, pass_count=0, last_sum=15.
- Timeout with TIMEOUT=15: model never asserts sum_valid -> ack never asserted, timeout_err=1, fail_count=1, done asserted 15 cycles after N_valid plus NEXT/DONE overhead.
- Wrap and ack hold:
  - Stimulus: sweep 6..1; model holds sum_valid 3 cycles after each ack rise.
  - Response: requests N=6,7,0,1, in that order.
  - Response: each ack high until sum_valid falls.
  - Response: pass_count=4.
- Reset mid-WAIT with start during busy:
  - Extra start pulses while busy are ignored; the range is unchanged.
  - Rst in WAIT leaves all outputs at their reset values the following cycle.
